// File: rtl/fetch_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_queue_if                                              |
// | Purpose  : Bundles the fetch queue's instruction-memory, redirect and  |
// |            decode-side signals. Names are given from the queue's point |
// |            of view (_i = into the queue, _o = out of the queue).       |
// | Modports : master - the fetch queue itself                             |
// |            slave  - the surrounding core (imem, branch unit, decode)   |
// | Signals  : pc_addr_o     fetch address to instruction memory          |
// |            instr_i       instruction word for pc_addr_o (comb.)        |
// |            redirect_i    flush + load new PC                           |
// |            redirect_pc_i redirect target                               |
// |            deq_ready_i   decode accepts head entry                     |
// |            instr_valid_o head entry valid                              |
// |            instr_o       head instruction                              |
// |            instr_pc_o    head fetch address                            |
// |            count_o       occupied entries                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface fetch_queue_if;
   logic [31:0] pc_addr_o;
   logic [31:0] instr_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        deq_ready_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic [3:0]  count_o;

   modport master (
      output pc_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o,
      input  instr_i, redirect_i, redirect_pc_i, deq_ready_i
   );

   modport slave (
      input  pc_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o,
      output instr_i, redirect_i, redirect_pc_i, deq_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_queue                                                 |
// | Purpose  : Instruction fetch PC generator plus a small circular queue  |
// |            of {fetch address, instruction} pairs feeding decode.       |
// |            One word is fetched per cycle whenever there is room (or    |
// |            the head is popped at the same edge). A redirect flushes    |
// |            the queue and reloads the PC.                               |
// | Ports    : clk_i  - clock, all state on rising edge                    |
// |            rst_i  - asynchronous active-high reset                     |
// |            bus    - fetch_queue_if.master (imem, redirect, decode)     |
// | Params   : DEPTH    - entry count, power of two in 2..8                |
// |            RESET_PC - PC loaded on reset                               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire logic     clk_i,
   input  wire logic     rst_i,
   fetch_queue_if.master bus
);

   localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

   // The PC is kept word-aligned by storing only bits [31:2]; this makes
   // the two low address bits structurally zero and the +4 step a +1.
   logic [31:2]      pc_q,     pc_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   // Entry storage needs no reset: the pointers and count define validity,
   // and the head outputs are forced to zero while empty.
   logic [31:0] ent_instr_q [DEPTH];
   logic [31:0] ent_pc_q    [DEPTH];

   logic not_empty;
   logic not_full;
   logic push;
   logic pop;

   assign not_empty = (count_q != '0);
   assign not_full  = (count_q != C_DEPTH);

   // A pop at the same edge frees the head slot, so a full queue can still
   // accept the word being fetched. The redirect blocks the push because the
   // word on instr_i belongs to the discarded path.
   assign pop  = not_empty && bus.deq_ready_i;
   assign push = !bus.redirect_i && (not_full || pop);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (bus.redirect_i) begin
         // Flush wins over any pop this cycle; the consumer still keeps the
         // head it accepted, the queue just does not need to track it.
         pc_d     = bus.redirect_pc_i[31:2];
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            // Power-of-two depth: pointer wrap is the natural overflow.
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            pc_d     = pc_q + 30'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + C_CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - C_CNT_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q     <= RESET_PC[31:2];
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ---------------------------------------------------------------------
   // Entry storage. When full with a pop, wr_ptr_q == rd_ptr_q: the old
   // head is read combinationally this cycle and overwritten at the edge.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (push) begin
         ent_instr_q[wr_ptr_q] <= bus.instr_i;
         ent_pc_q[wr_ptr_q]    <= {pc_q, 2'b00};
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.pc_addr_o     = {pc_q, 2'b00};
   assign bus.instr_valid_o = not_empty;
   assign bus.instr_o       = not_empty ? ent_instr_q[rd_ptr_q] : 32'h0;
   assign bus.instr_pc_o    = not_empty ? ent_pc_q[rd_ptr_q]    : 32'h0;
   assign bus.count_o       = 4'(count_q);

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_fetch_queue                                              |
// | Purpose  : Self-checking bench for fetch_queue. Instruction memory is  |
// |            modelled as word(addr) = (addr >> 2) ^ mem_key. A queue-    |
// |            based reference model tracks expected contents and PC.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic [31:0] mem_key = 32'h0;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: FIFO of {pc, instr} plus the fetch PC.
   logic [31:0] mq_pc [$];
   logic [31:0] mq_in [$];
   logic [31:0] m_pc;

   fetch_queue_if bus ();

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   assign bus.instr_i = (bus.pc_addr_o >> 2) ^ mem_key;

   function automatic logic [31:0] exp_instr();
      return (mq_in.size() != 0) ? mq_in[0] : 32'h0;
   endfunction

   function automatic logic [31:0] exp_ipc();
      return (mq_pc.size() != 0) ? mq_pc[0] : 32'h0;
   endfunction

   // Drive one cycle of inputs, let the edge happen, advance the model,
   // and return 2 time units after the edge for sampling.
   task automatic drive_cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
      int sz;
      bit pop;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = rpc;
      bus.deq_ready_i   = rdy;
      sz  = mq_pc.size();
      pop = (sz != 0) && rdy;
      @(posedge clk_i);
      if (redir) begin
         mq_pc.delete();
         mq_in.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_in.pop_front());
         end
         if (sz < DEPTH || pop) begin
            mq_pc.push_back(m_pc);
            mq_in.push_back((m_pc >> 2) ^ mem_key);
            m_pc = m_pc + 32'd4;
         end
      end
      #2;
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      rst_i             = 1'b1;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      bus.deq_ready_i   = 1'b0;
      mq_pc.delete();
      mq_in.delete();
      m_pc = RESET_PC;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // -------------------------------------------------------------------
   task automatic test_reset();
      apply_reset();
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if (bus.count_o !== 4'd0) begin
         n_err++; $display("FAIL reset_count: got %0d want 0", bus.count_o);
      end
      n_cmp++;
      if (bus.instr_valid_o !== 1'b0) begin
         n_err++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid_o);
      end
      n_cmp++;
      if (bus.instr_o !== 32'h0 || bus.instr_pc_o !== 32'h0) begin
         n_err++; $display("FAIL reset_head: got %h/%h want 0/0", bus.instr_o, bus.instr_pc_o);
      end
      n_cmp++;
      if (bus.pc_addr_o !== RESET_PC) begin
         n_err++; $display("FAIL reset_pc: got %h want %h", bus.pc_addr_o, RESET_PC);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Continuous streaming with decode always ready.
   task automatic test_stream();
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_cmp++;
         if (bus.count_o !== 4'd1 || bus.instr_pc_o !== 32'(4 * k) || bus.instr_o !== 32'(k)) begin
            n_err++;
            $display("FAIL stream[%0d]: got cnt=%0d pc=%h ins=%h want cnt=1 pc=%h ins=%h",
                     k, bus.count_o, bus.instr_pc_o, bus.instr_o, 32'(4 * k), 32'(k));
         end
      end
   endtask

   // Fill to full with decode stalled, then drain in order.
   task automatic test_fill_stall();
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         drive_cycle(1'b0, 32'h0, 1'b0);
         n_cmp++;
         if (bus.count_o !== 4'((k < 3) ? k + 1 : 4) || bus.instr_pc_o !== 32'h0) begin
            n_err++;
            $display("FAIL fill[%0d]: got cnt=%0d head=%h want cnt=%0d head=0",
                     k, bus.count_o, bus.instr_pc_o, (k < 3) ? k + 1 : 4);
         end
      end
      n_cmp++;
      if (bus.pc_addr_o !== 32'h10) begin
         n_err++; $display("FAIL stall_pc: got %h want 00000010", bus.pc_addr_o);
      end
      for (int k = 0; k < 6; k++) begin
         // Head before the popping edge must be the k-th fetched word.
         n_cmp++;
         if (bus.instr_pc_o !== 32'(4 * k) || bus.instr_o !== 32'(k)) begin
            n_err++;
            $display("FAIL drain[%0d]: got pc=%h ins=%h want pc=%h ins=%h",
                     k, bus.instr_pc_o, bus.instr_o, 32'(4 * k), 32'(k));
         end
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_cmp++;
         if (bus.count_o !== 4'd4) begin
            n_err++; $display("FAIL drain_count[%0d]: got %0d want 4", k, bus.count_o);
         end
      end
   endtask

   // Redirect with 3 entries queued, unaligned target.
   task automatic test_redirect();
      apply_reset();
      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (bus.count_o !== 4'd3) begin
         n_err++; $display("FAIL redir_pre_count: got %0d want 3", bus.count_o);
      end
      drive_cycle(1'b1, 32'h47, 1'b0);
      n_cmp++;
      if (bus.count_o !== 4'd0 || bus.instr_valid_o !== 1'b0 || bus.pc_addr_o !== 32'h44) begin
         n_err++;
         $display("FAIL redir_flush: got cnt=%0d v=%b pc=%h want cnt=0 v=0 pc=00000044",
                  bus.count_o, bus.instr_valid_o, bus.pc_addr_o);
      end
      drive_cycle(1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (bus.instr_pc_o !== 32'h44 || bus.instr_o !== 32'h11 || bus.count_o !== 4'd1) begin
         n_err++;
         $display("FAIL redir_first: got pc=%h ins=%h cnt=%0d want pc=00000044 ins=00000011 cnt=1",
                  bus.instr_pc_o, bus.instr_o, bus.count_o);
      end
   endtask

   // PC wrap through 2^32.
   task automatic test_wrap();
      logic [31:0] want [3];
      want[0] = 32'hFFFF_FFF8;
      want[1] = 32'hFFFF_FFFC;
      want[2] = 32'h0000_0000;
      drive_cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_cmp++;
         if (bus.instr_pc_o !== want[k] || bus.instr_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL wrap[%0d]: got pc=%h v=%b want pc=%h v=1",
                     k, bus.instr_pc_o, bus.instr_valid_o, want[k]);
         end
      end
   endtask

   // Full queue, pop and redirect in the same cycle.
   task automatic test_full_pop_redirect();
      logic [31:0] old_head;
      apply_reset();
      for (int k = 0; k < 5; k++) drive_cycle(1'b0, 32'h0, 1'b0);
      old_head = bus.instr_pc_o;
      n_cmp++;
      if (old_head !== 32'h0 || bus.count_o !== 4'd4) begin
         n_err++; $display("FAIL fpr_pre: got head=%h cnt=%0d want head=0 cnt=4", old_head, bus.count_o);
      end
      drive_cycle(1'b1, 32'h100, 1'b1);
      n_cmp++;
      if (bus.count_o !== 4'd0 || bus.instr_valid_o !== 1'b0) begin
         n_err++; $display("FAIL fpr_empty: got cnt=%0d v=%b want 0/0", bus.count_o, bus.instr_valid_o);
      end
      for (int k = 0; k < 6; k++) begin
         drive_cycle(1'b0, 32'h0, 1'b1);
         n_cmp++;
         if (bus.instr_pc_o !== 32'(32'h100 + 4 * k)) begin
            n_err++;
            $display("FAIL fpr_stale[%0d]: got pc=%h want %h", k, bus.instr_pc_o, 32'(32'h100 + 4 * k));
         end
      end
   endtask

   // Back-to-back redirects: the last one defines the next fetch.
   task automatic test_back_to_back();
      drive_cycle(1'b1, 32'h200, 1'b0);
      drive_cycle(1'b1, 32'h300, 1'b1);
      drive_cycle(1'b1, 32'h407, 1'b0);
      n_cmp++;
      if (bus.pc_addr_o !== 32'h404 || bus.count_o !== 4'd0) begin
         n_err++; $display("FAIL b2b_pc: got pc=%h cnt=%0d want 00000404/0", bus.pc_addr_o, bus.count_o);
      end
      drive_cycle(1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (bus.instr_pc_o !== 32'h404) begin
         n_err++; $display("FAIL b2b_head: got %h want 00000404", bus.instr_pc_o);
      end
   endtask

   // Asynchronous reset while full.
   task automatic test_async_reset();
      apply_reset();
      for (int k = 0; k < 5; k++) drive_cycle(1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (bus.count_o !== 4'd4) begin
         n_err++; $display("FAIL areset_pre: got %0d want 4", bus.count_o);
      end
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if (bus.count_o !== 4'd0 || bus.instr_valid_o !== 1'b0 || bus.pc_addr_o !== RESET_PC) begin
         n_err++;
         $display("FAIL areset: got cnt=%0d v=%b pc=%h want 0/0/%h",
                  bus.count_o, bus.instr_valid_o, bus.pc_addr_o, RESET_PC);
      end
      mq_pc.delete();
      mq_in.delete();
      m_pc = RESET_PC;
      @(negedge clk_i);
      rst_i = 1'b0;
      drive_cycle(1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (bus.count_o !== 4'd1 || bus.instr_pc_o !== RESET_PC) begin
         n_err++; $display("FAIL areset_post: got cnt=%0d pc=%h want 1/%h", bus.count_o, bus.instr_pc_o, RESET_PC);
      end
   endtask

   // Random traffic against the reference model.
   task automatic test_random();
      logic        redir;
      logic        rdy;
      logic [31:0] rpc;
      mem_key = $urandom;
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         redir = ($urandom_range(0, 9) == 0);
         rdy   = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
         rpc   = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : 32'h0) | ($urandom & 32'h0000_0FFF);
         drive_cycle(redir, rpc, rdy);
         n_cmp++;
         if (bus.count_o !== 4'(mq_pc.size()) ||
             bus.instr_valid_o !== (mq_pc.size() != 0) ||
             bus.instr_o !== exp_instr() ||
             bus.instr_pc_o !== exp_ipc() ||
             bus.pc_addr_o !== m_pc) begin
            n_err++;
            $display("FAIL random[%0d]: got cnt=%0d v=%b ins=%h ipc=%h pc=%h want cnt=%0d v=%b ins=%h ipc=%h pc=%h",
                     k, bus.count_o, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, bus.pc_addr_o,
                     mq_pc.size(), (mq_pc.size() != 0), exp_instr(), exp_ipc(), m_pc);
         end
      end
      mem_key = 32'h0;
   endtask

   initial begin
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      bus.deq_ready_i   = 1'b0;
      m_pc              = RESET_PC;
      test_reset();
      test_stream();
      test_fill_stall();
      test_redirect();
      test_wrap();
      test_full_pop_redirect();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entry count (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pc_addr_o  output  32  fetch address driven to instruction memory pc_addr_i.
REQ-006 SHALL have port instr_i  input  32  instruction word returned combinationally by instruction memory for pc_addr_o.
REQ-007 SHALL have port redirect_i  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc_i  input  32  redirect target address.
REQ-009 SHALL have port deq_ready_i  input  1  decode stage accepts head entry this cycle.
REQ-010 SHALL have port instr_valid_o  output  1  head entry valid.
REQ-011 SHALL have port instr_o  output  32  head entry instruction.
REQ-012 SHALL have port instr_pc_o  output  32  head entry fetch address.
REQ-013 SHALL have port count_o  output  4  current number of occupied entries (0..DEPTH).

Function
REQ-014 SHALL hold a fetch PC register driven directly on pc_addr_o; pc_addr_o[1:0] SHALL always be 2'b00.
REQ-015 SHALL define push = !redirect_i && (count < DEPTH || pop); pop = instr_valid_o && deq_ready_i.
REQ-016 On push, SHALL write {pc_addr_o, instr_i} into the tail entry and advance PC by 4 at the same edge (fetch-to-queue latency 1 cycle).
REQ-017 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-018 When count = DEPTH and no pop, SHALL not push and SHALL hold PC (fetch stall).
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when full (full-with-pop accepts a new entry) and when count = 1.
REQ-020 Push into an empty queue SHALL not be visible on instr_valid_o until the following cycle (no combinational bypass instr_i to instr_o).
REQ-021 instr_valid_o SHALL equal (count != 0); instr_o/instr_pc_o SHALL show the head entry, and SHALL be 32'h0 when count = 0.
REQ-022 On redirect_i, at the edge: all entries SHALL be discarded (count = 0, pointers reset), PC SHALL load {redirect_pc_i[31:2], 2'b00}, no push SHALL occur.
REQ-023 A pop asserted in the redirect cycle SHALL count as accepted by the consumer; the flush SHALL override it.
REQ-024 Redirect while queue empty or full SHALL behave identically to REQ-022.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH nor underflow below 0.
REQ-026 Back-to-back redirects SHALL each take effect; the last one before a non-redirect cycle defines the PC fetched next.
REQ-027 Queue output SHALL be stable while instr_valid_o = 1 and deq_ready_i = 0 (no change to head without pop or redirect).

Reset
REQ-028 While rst_i = 1, asynchronously: PC = RESET_PC, count_o = 0, pointers = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0.
REQ-029 Reset asserted mid-operation (including during a redirect or full stall) SHALL discard all entries and pending redirect.
REQ-030 On first rising edge after rst_i deasserts, SHALL push the instruction at RESET_PC if not full.

Verification
REQ-031 Reset release, deq_ready_i = 1, memory word k = k -> instr_pc_o 0,4,8,... and instr_o 0,1,2,... one per cycle from cycle 2, count_o steady at 1.
REQ-032 deq_ready_i = 0 for 10 cycles from reset -> count_o 1,2,3,4 then holds 4, pc_addr_o holds 32'h10; then deq_ready_i = 1 -> entries at PC 0,4,8,C drain in order, fetch resumes at 32'h10 with count_o 4.
REQ-033 Queue holding 3 entries, redirect_i = 1 with redirect_pc_i = 32'h47 -> next cycle count_o = 0, instr_valid_o = 0, pc_addr_o = 32'h44; following cycle instr_pc_o = 32'h44.
REQ-034 Redirect to 32'hFFFF_FFF8, deq_ready_i = 1 -> instr_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 Full queue, pop and redirect in same cycle -> consumer receives old head once, queue empty next cycle, no stale entry ever reappears.
REQ-036 rst_i pulsed asynchronously between edges while count_o = 4 -> count_o, instr_valid_o drop to 0 immediately, pc_addr_o = RESET_PC.
